// File: rtl/mips_pkg.sv
// Shared opcodes, function codes, ALU operations and reset/interrupt defaults
// for the single-cycle MIPS-subset core.
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
    localparam logic [31:0] INT_VECTOR_DEF = 32'h0000_0004;
    localparam logic [31:0] ERET_INST      = 32'h4200_0018;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_COP0  = 6'h10;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
    } alu_op_e;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_single_cycle_cpu_if.sv
// Instruction/data memory bus between the core (master) and IM/DM/IO (slave).
interface mips_single_cycle_cpu_if;
    logic        MIO_ready;
    logic [31:0] inst_in;
    logic [31:0] Data_in;
    logic        mem_w;
    logic [31:0] PC_out;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic        CPU_MIO;

    modport master (
        input  MIO_ready, inst_in, Data_in,
        output mem_w, PC_out, Addr_out, Data_out, CPU_MIO
    );

    modport slave (
        output MIO_ready, inst_in, Data_in,
        input  mem_w, PC_out, Addr_out, Data_out, CPU_MIO
    );
endinterface

// File: rtl/mips_regfile.sv
// 32x32 register file, two combinational read ports and one write port;
// $0 reads as zero and ignores writes.
module mips_regfile (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    input  logic [4:0]  wa,
    input  logic        we,
    input  logic [31:0] wd,
    output logic [31:0] rd1,
    output logic [31:0] rd2
);
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && wa != 5'd0) regs_d[wa] = wd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];
endmodule

// File: rtl/mips_single_cycle_cpu.sv
// Single-cycle MIPS-subset core: one instruction fetched, executed and retired per clock.
// Define SCPU_INT_EN to add the external interrupt (EPC/IE state and eret).
module mips_single_cycle_cpu
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter logic [31:0] INT_VECTOR = INT_VECTOR_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    INT,
    mips_single_cycle_cpu_if.master bus
);
    logic [31:0] pc_q, pc_d;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] rs_val, rt_val, alu_b, alu_y, imm_ext, wr_data;
    logic [31:0] pc_plus4, br_target, jmp_target;
    alu_op_e     alu_op;
    logic        use_imm, zero_ext, reg_we, retire;
    logic        is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr, is_eret;
    logic [4:0]  wr_addr;

    assign op    = bus.inst_in[31:26];
    assign rs    = bus.inst_in[25:21];
    assign rt    = bus.inst_in[20:16];
    assign rd    = bus.inst_in[15:11];
    assign shamt = bus.inst_in[10:6];
    assign fn    = bus.inst_in[5:0];
    assign imm   = bus.inst_in[15:0];

    always_comb begin
        alu_op   = ALU_ADD;
        use_imm  = 1'b0;
        zero_ext = 1'b0;
        reg_we   = 1'b0;
        wr_addr  = rt;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        is_jal   = 1'b0;
        is_jr    = 1'b0;
        is_eret  = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_we  = 1'b1;
                wr_addr = rd;
                case (fn)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_XOR:          alu_op = ALU_XOR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    FN_SLTU:         alu_op = ALU_SLTU;
                    FN_SLL:          alu_op = ALU_SLL;
                    FN_SRL:          alu_op = ALU_SRL;
                    FN_SRA:          alu_op = ALU_SRA;
                    FN_JR: begin
                        reg_we = 1'b0;
                        is_jr  = 1'b1;
                    end
                    default:         reg_we = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin reg_we = 1'b1; use_imm = 1'b1; end
            OP_SLTI:  begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLT;  end
            OP_SLTIU: begin reg_we = 1'b1; use_imm = 1'b1; alu_op = ALU_SLTU; end
            OP_ANDI:  begin reg_we = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_AND; end
            OP_ORI:   begin reg_we = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_OR;  end
            OP_XORI:  begin reg_we = 1'b1; use_imm = 1'b1; zero_ext = 1'b1; alu_op = ALU_XOR; end
            OP_LUI:   begin reg_we = 1'b1; alu_op = ALU_LUI; end
            OP_LW:    begin reg_we = 1'b1; use_imm = 1'b1; is_lw = 1'b1; end
            OP_SW:    begin use_imm = 1'b1; is_sw = 1'b1; end
            OP_BEQ:   is_beq = 1'b1;
            OP_BNE:   is_bne = 1'b1;
            OP_J:     is_j = 1'b1;
            OP_JAL: begin
                is_j    = 1'b1;
                is_jal  = 1'b1;
                reg_we  = 1'b1;
                wr_addr = 5'd31;
            end
`ifdef SCPU_INT_EN
            OP_COP0:  is_eret = (bus.inst_in == ERET_INST);
`endif
            default: ;
        endcase
    end

    assign imm_ext = zero_ext ? {16'h0000, imm} : sext16(imm);
    assign alu_b   = use_imm ? imm_ext : rt_val;

    always_comb begin
        case (alu_op)
            ALU_ADD:  alu_y = rs_val + alu_b;
            ALU_SUB:  alu_y = rs_val - alu_b;
            ALU_AND:  alu_y = rs_val & alu_b;
            ALU_OR:   alu_y = rs_val | alu_b;
            ALU_XOR:  alu_y = rs_val ^ alu_b;
            ALU_NOR:  alu_y = ~(rs_val | alu_b);
            ALU_SLT:  alu_y = {31'b0, $signed(rs_val) < $signed(alu_b)};
            ALU_SLTU: alu_y = {31'b0, rs_val < alu_b};
            ALU_SLL:  alu_y = alu_b << shamt;
            ALU_SRL:  alu_y = alu_b >> shamt;
            ALU_SRA:  alu_y = $signed(alu_b) >>> shamt;
            ALU_LUI:  alu_y = {imm, 16'h0000};
            default:  alu_y = rs_val + alu_b;
        endcase
    end

    assign pc_plus4   = pc_q + 32'd4;
    assign br_target  = pc_plus4 + {imm_ext[29:0], 2'b00};
    assign jmp_target = {pc_plus4[31:28], bus.inst_in[25:0], 2'b00};
    assign wr_data    = is_lw ? bus.Data_in : (is_jal ? pc_plus4 : alu_y);

`ifdef SCPU_INT_EN
    logic [31:0] epc_q, epc_d;
    logic        ie_q, ie_d, take_int;

    // An accepted interrupt squashes the instruction currently on inst_in.
    assign take_int = INT && ie_q;
    assign retire   = !take_int;

    always_comb begin
        epc_d = epc_q;
        ie_d  = ie_q;
        if (take_int) begin
            epc_d = pc_q;
            ie_d  = 1'b0;
        end else if (is_eret) begin
            ie_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            epc_q <= '0;
            ie_q  <= 1'b1;
        end else begin
            epc_q <= epc_d;
            ie_q  <= ie_d;
        end
    end
`else
    logic unused_int;
    assign retire     = 1'b1;
    assign unused_int = ^{INT, INT_VECTOR, is_eret, ERET_INST, OP_COP0};
`endif

    always_comb begin
        pc_d = pc_plus4;
        if (is_jr)                                  pc_d = rs_val;
        else if (is_j)                              pc_d = jmp_target;
        else if ((is_beq && rs_val == rt_val) ||
                 (is_bne && rs_val != rt_val))      pc_d = br_target;
`ifdef SCPU_INT_EN
        if (is_eret)  pc_d = epc_q;
        if (take_int) pc_d = INT_VECTOR;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    mips_regfile u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .wa    (wr_addr),
        .we    (reg_we && retire),
        .wd    (wr_data),
        .rd1   (rs_val),
        .rd2   (rt_val)
    );

    logic unused_bus;
    assign unused_bus = bus.MIO_ready;

    assign bus.PC_out   = pc_q;
    assign bus.Addr_out = alu_y;
    assign bus.Data_out = rt_val;
    assign bus.mem_w    = is_sw && retire && reset;
    assign bus.CPU_MIO  = (is_lw || is_sw) && retire && reset;
endmodule

// File: tb/tb_mips_single_cycle_cpu.sv
// Bench for mips_single_cycle_cpu: directed program table, interrupt sequence,
// and random instructions against an instruction-level reference model.
module tb_mips_single_cycle_cpu;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic int_in = 1'b0;

    mips_single_cycle_cpu_if bus ();

    mips_single_cycle_cpu dut (
        .clk   (clk),
        .reset (reset),
        .INT   (int_in),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Apply one instruction for the coming clock edge; outputs settle 1ns later.
    task automatic drive(input logic [31:0] ins, input logic [31:0] din,
                         input logic rst_v, input logic int_v);
        @(negedge clk);
        reset         = rst_v;
        int_in        = int_v;
        bus.inst_in   = ins;
        bus.Data_in   = din;
        bus.MIO_ready = 1'b1;
        #1;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_pc = 32'h0;
    endtask

    task automatic model_exec(input logic [31:0] ins, input logic [31:0] din,
                              output logic [31:0] e_dout, output logic e_mw,
                              output logic e_mio, output logic [31:0] e_addr);
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd, sh, dst;
        logic [31:0] a, b, se, ze, nxt, val;
        logic        wr;
        op = ins[31:26]; rs = ins[25:21]; rt = ins[20:16];
        rd = ins[15:11]; sh = ins[10:6];  fn = ins[5:0];
        a  = m_regs[rs]; b = m_regs[rt];
        se = {{16{ins[15]}}, ins[15:0]};
        ze = {16'h0, ins[15:0]};
        nxt = m_pc + 32'd4;
        wr = 1'b0; dst = rt; val = '0;
        e_dout = b; e_mw = 1'b0; e_mio = 1'b0; e_addr = '0;
        case (op)
            6'h00: begin
                wr = 1'b1; dst = rd;
                case (fn)
                    6'h20, 6'h21: val = a + b;
                    6'h22, 6'h23: val = a - b;
                    6'h24: val = a & b;
                    6'h25: val = a | b;
                    6'h26: val = a ^ b;
                    6'h27: val = ~(a | b);
                    6'h2A: val = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                    6'h2B: val = (a < b) ? 32'd1 : 32'd0;
                    6'h00: val = b << sh;
                    6'h02: val = b >> sh;
                    6'h03: val = $signed(b) >>> sh;
                    6'h08: begin wr = 1'b0; nxt = a; end
                    default: wr = 1'b0;
                endcase
            end
            6'h08, 6'h09: begin wr = 1'b1; val = a + se; end
            6'h0A: begin wr = 1'b1; val = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0B: begin wr = 1'b1; val = (a < se) ? 32'd1 : 32'd0; end
            6'h0C: begin wr = 1'b1; val = a & ze; end
            6'h0D: begin wr = 1'b1; val = a | ze; end
            6'h0E: begin wr = 1'b1; val = a ^ ze; end
            6'h0F: begin wr = 1'b1; val = ins[15:0] * 32'h10000; end
            6'h23: begin wr = 1'b1; val = din; e_mio = 1'b1; e_addr = a + se; end
            6'h2B: begin e_mw = 1'b1; e_mio = 1'b1; e_addr = a + se; end
            6'h04: if (a == b) nxt = m_pc + 32'd4 + se * 4;
            6'h05: if (a != b) nxt = m_pc + 32'd4 + se * 4;
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            6'h03: begin
                wr = 1'b1; dst = 5'd31; val = m_pc + 32'd4;
                nxt = {nxt[31:28], ins[25:0], 2'b00};
            end
            default: ;
        endcase
        if (wr && dst != 5'd0) m_regs[dst] = val;
        m_pc = nxt;
    endtask

    // ---------------- random instruction source ----------------
    logic [5:0] r_fn [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                              6'h27, 6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h01};
    logic [5:0] i_op [8]  = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F};

    function automatic logic [31:0] rand_inst();
        logic [4:0]  rs, rt, rd, sh;
        logic [15:0] imm;
        logic [31:0] ins;
        rs  = 5'($urandom_range(0, 7));
        rt  = 5'($urandom_range(0, 7));
        rd  = 5'($urandom_range(0, 7));
        sh  = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        case ($urandom_range(0, 13))
            0, 1, 2, 3: ins = {6'h00, rs, rt, rd, sh, r_fn[$urandom_range(0, 13)]};
            4, 5, 6:    ins = {i_op[$urandom_range(0, 7)], rs, rt, imm};
            7:          ins = {6'h23, rs, rt, imm};
            8:          ins = {6'h2B, rs, rt, imm};
            9:          ins = {6'h04, rs, (($urandom_range(0, 1) == 1) ? rs : rt), imm};
            10:         ins = {6'h05, rs, rt, imm};
            11:         ins = {(($urandom_range(0, 1) == 1) ? 6'h02 : 6'h03), 26'($urandom)};
            12:         ins = {6'h00, (($urandom_range(0, 3) == 0) ? 5'd31 : rs), 15'h0, 6'h08};
            default:    ins = {6'h3F, rs, rt, imm};
        endcase
        return ins;
    endfunction

    // ---------------- directed program table ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] din;
        logic        mw;
        logic        mio;
        logic        chk_a;
        logic [31:0] addr;
        logic [31:0] dout;
    } vec_t;

    vec_t vt [20];

    function automatic vec_t mkv(input logic [31:0] pc, input logic [31:0] inst,
                                 input logic [31:0] din, input logic mw, input logic mio,
                                 input logic chk_a, input logic [31:0] addr,
                                 input logic [31:0] dout);
        vec_t v;
        v.pc = pc; v.inst = inst; v.din = din; v.mw = mw; v.mio = mio;
        v.chk_a = chk_a; v.addr = addr; v.dout = dout;
        return v;
    endfunction

    initial begin
        logic [31:0] ins, din, e_dout, e_addr;
        logic        e_mw, e_mio, int_v;

        bus.inst_in   = 32'hAC03_0008;
        bus.Data_in   = '0;
        bus.MIO_ready = 1'b1;

        // program: arithmetic, branches, jal/jr, store/load, $0 write, then register probes
        vt[0]  = mkv(32'h000, 32'h2001_0005, 0, 0, 0, 0, 0, 32'h0);
        vt[1]  = mkv(32'h004, 32'h2002_FFFD, 0, 0, 0, 0, 0, 32'h0);
        vt[2]  = mkv(32'h008, 32'h0022_1820, 0, 0, 0, 0, 0, 32'hFFFF_FFFD);
        vt[3]  = mkv(32'h00C, 32'h0041_202A, 0, 0, 0, 0, 0, 32'h5);
        vt[4]  = mkv(32'h010, 32'h1021_0002, 0, 0, 0, 0, 0, 32'h5);
        vt[5]  = mkv(32'h01C, 32'h1421_0002, 0, 0, 0, 0, 0, 32'h5);
        vt[6]  = mkv(32'h020, 32'h0C00_0040, 0, 0, 0, 0, 0, 32'h0);
        vt[7]  = mkv(32'h100, 32'h0041_282B, 0, 0, 0, 0, 0, 32'h5);
        vt[8]  = mkv(32'h104, 32'hAC03_0008, 0, 1, 1, 1, 32'h8, 32'h2);
        vt[9]  = mkv(32'h108, 32'h8C06_0008, 2, 0, 1, 1, 32'h8, 32'h0);
        vt[10] = mkv(32'h10C, 32'h2000_0007, 0, 0, 0, 0, 0, 32'h0);
        vt[11] = mkv(32'h110, 32'h03E0_0008, 0, 0, 0, 0, 0, 32'h0);
        vt[12] = mkv(32'h024, 32'h0003_0024, 0, 0, 0, 0, 0, 32'h2);
        vt[13] = mkv(32'h028, 32'h0004_0024, 0, 0, 0, 0, 0, 32'h1);
        vt[14] = mkv(32'h02C, 32'h0005_0024, 0, 0, 0, 0, 0, 32'h0);
        vt[15] = mkv(32'h030, 32'h0006_0024, 0, 0, 0, 0, 0, 32'h2);
        vt[16] = mkv(32'h034, 32'h001F_0024, 0, 0, 0, 0, 0, 32'h24);
        vt[17] = mkv(32'h038, 32'h0000_0024, 0, 0, 0, 0, 0, 32'h0);
        vt[18] = mkv(32'h03C, 32'h0001_0024, 0, 0, 0, 0, 0, 32'h5);
        vt[19] = mkv(32'h040, 32'h0002_0024, 0, 0, 0, 0, 0, 32'hFFFF_FFFD);

        // reset held two cycles with a store on the bus
        for (int k = 0; k < 2; k++) begin
            drive(32'hAC03_0008, 0, 1'b0, 1'b0);
            check($sformatf("rst%0d_pc", k), bus.PC_out, 32'h0);
            check($sformatf("rst%0d_mem_w", k), {31'b0, bus.mem_w}, 32'h0);
            check($sformatf("rst%0d_mio", k), {31'b0, bus.CPU_MIO}, 32'h0);
        end
        for (int k = 0; k < 3; k++) begin
            drive(32'h0, 0, 1'b1, 1'b0);
            check($sformatf("rel%0d_pc", k), bus.PC_out, 32'(4 * k));
        end
        drive(32'h0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            drive(vt[i].inst, vt[i].din, 1'b1, 1'b0);
            check($sformatf("vec%0d_pc", i), bus.PC_out, vt[i].pc);
            check($sformatf("vec%0d_mem_w", i), {31'b0, bus.mem_w}, {31'b0, vt[i].mw});
            check($sformatf("vec%0d_mio", i), {31'b0, bus.CPU_MIO}, {31'b0, vt[i].mio});
            check($sformatf("vec%0d_dout", i), bus.Data_out, vt[i].dout);
            if (vt[i].chk_a) check($sformatf("vec%0d_addr", i), bus.Addr_out, vt[i].addr);
        end

        // interrupt sequence: j 0x30, then INT raised while addi $7,$0,9 is presented
        drive(32'h0800_000C, 0, 1'b1, 1'b0);
        check("j_pc", bus.PC_out, 32'h44);
        drive(32'h2007_0009, 0, 1'b1, 1'b1);
        check("int_pc", bus.PC_out, 32'h30);
`ifdef SCPU_INT_EN
        drive(32'h4200_0018, 0, 1'b1, 1'b1);
        check("vec_pc", bus.PC_out, 32'h4);
        drive(32'h0007_0024, 0, 1'b1, 1'b0);
        check("eret_pc", bus.PC_out, 32'h30);
        check("squashed_r7", bus.Data_out, 32'h0);
`else
        drive(32'h4200_0018, 0, 1'b1, 1'b1);
        check("noint_pc", bus.PC_out, 32'h34);
        drive(32'h0007_0024, 0, 1'b1, 1'b0);
        check("eret_nop_pc", bus.PC_out, 32'h38);
        check("retired_r7", bus.Data_out, 32'h9);
`endif

        // random instructions from a fresh reset against the reference model
        drive(32'h0, 0, 1'b0, 1'b0);
        model_reset();
        for (int n = 0; n < 400; n++) begin
            ins = rand_inst();
            din = $urandom;
`ifdef SCPU_INT_EN
            int_v = 1'b0;
`else
            int_v = 1'($urandom_range(0, 1));
`endif
            drive(ins, din, 1'b1, int_v);
            check($sformatf("rnd%0d_pc", n), bus.PC_out, m_pc);
            model_exec(ins, din, e_dout, e_mw, e_mio, e_addr);
            check($sformatf("rnd%0d_dout", n), bus.Data_out, e_dout);
            check($sformatf("rnd%0d_mem_w", n), {31'b0, bus.mem_w}, {31'b0, e_mw});
            check($sformatf("rnd%0d_mio", n), {31'b0, bus.CPU_MIO}, {31'b0, e_mio});
            if (e_mio) check($sformatf("rnd%0d_addr", n), bus.Addr_out, e_addr);
        end
        drive(32'h0, 0, 1'b1, 1'b0);
        check("rnd_final_pc", bus.PC_out, m_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
